// File: rtl/seg_display_arbiter_if.sv
// Requester handshakes and display outputs of the two-digit display arbiter.
// The master side drives the requests; the slave side is the arbiter itself.
interface seg_display_arbiter_if;
    logic       Req0_Valid;
    logic [7:0] Req0_Data;
    logic       Req0_Ready;
    logic       Req1_Valid;
    logic [7:0] Req1_Data;
    logic       Req1_Ready;
    logic [3:0] Digit1_Nibble;
    logic [3:0] Digit2_Nibble;
    logic       Digit_Enable;
    logic       Owner;

    modport master (
        output Req0_Valid, Req0_Data, Req1_Valid, Req1_Data,
        input  Req0_Ready, Req1_Ready, Digit1_Nibble, Digit2_Nibble, Digit_Enable, Owner
    );

    modport slave (
        input  Req0_Valid, Req0_Data, Req1_Valid, Req1_Data,
        output Req0_Ready, Req1_Ready, Digit1_Nibble, Digit2_Nibble, Digit_Enable, Owner
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin sharing of a two-digit 7-segment display between two requesters,
// with a minimum hold time per grant and a blanking gap on ownership change.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES  = 25000000,
    parameter int BLANK_CYCLES = 2500000
) (
    input  logic                  CLK,
    input  logic                  RST,
    seg_display_arbiter_if.slave  bus
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pending_q, pending_d;
    logic [7:0]    digits_q, digits_d;
    logic          enable_q, enable_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;

    logic          grant_idx;
    logic          ready0, ready1;
    logic          xfer;
    logic          xfer_idx;
    logic [7:0]    xfer_data;

    // Ready depends only on state, owner, last grant and the valids; a tie goes to !last_grant.
    always_comb begin
        grant_idx = (bus.Req0_Valid && bus.Req1_Valid) ? ~last_grant_q : bus.Req1_Valid;
        ready0    = 1'b0;
        ready1    = 1'b0;
        case (state_q)
            IDLE: begin
                ready0 = (bus.Req0_Valid || bus.Req1_Valid) && !grant_idx;
                ready1 = (bus.Req0_Valid || bus.Req1_Valid) &&  grant_idx;
            end
            SHOW: begin
                ready0 = !owner_q;
                ready1 =  owner_q;
            end
            default: begin
                ready0 = 1'b0;
                ready1 = 1'b0;
            end
        endcase
        xfer      = (ready0 && bus.Req0_Valid) || (ready1 && bus.Req1_Valid);
        xfer_idx  = ready1;
        xfer_data = ready1 ? bus.Req1_Data : bus.Req0_Data;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        digits_d     = digits_q;
        enable_d     = enable_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    pending_d    = xfer_data;
                    last_grant_d = xfer_idx;
                    owner_d      = xfer_idx;
                    if (enable_q && (xfer_idx != owner_q) && (BLANK_CYCLES > 0)) begin
                        enable_d = 1'b0;
                        cnt_d    = BLANK_LOAD;
                        state_d  = GAP;
                    end else begin
                        digits_d = xfer_data;
                        enable_d = 1'b1;
                        cnt_d    = HOLD_LOAD;
                        state_d  = SHOW;
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    digits_d = pending_q;
                    enable_d = 1'b1;
                    cnt_d    = HOLD_LOAD;
                    state_d  = SHOW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SHOW: begin
                // Owner updates refresh the digits but never extend the hold period.
                if (xfer) begin
                    digits_d  = xfer_data;
                    pending_d = xfer_data;
                end
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= '0;
            digits_q     <= '0;
            enable_q     <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            digits_q     <= digits_d;
            enable_q     <= enable_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.Req0_Ready    = ready0;
    assign bus.Req1_Ready    = ready1;
    assign bus.Digit1_Nibble = digits_q[7:4];
    assign bus.Digit2_Nibble = digits_q[3:0];
    assign bus.Digit_Enable  = enable_q;
    assign bus.Owner         = owner_q;
endmodule
